mips_cache_instr_fill: RTL
==========================

# mips_cache_instr_fill

Refill engine between the instruction cache and the Avalon-style memory bus. When the instruction cache raises `stall` on a read miss, this block latches the word address, performs a single-word bus read, and returns the word on `data_in`/`data_valid` for exactly one cycle. It is the responder end of the cache's `stall` / `data_in` / `data_valid` refill interface.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width; the only supported value is 32.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `addr` in 32: CPU fetch byte address (the same net the cache sees).
- `stall` in 1: cache miss request; high = word at `addr` needed.
- `data_in` out 32: refill word to cache; reset 0.
- `data_valid` out 1: one-cycle strobe qualifying `data_in`; reset 0.
- `mem_address` out 32: bus byte address, word-aligned; reset 0.
- `mem_read` out 1: bus read request; reset 0.
- `mem_byteenable` out 4: constant 4'b1111 while `mem_read`=1, else 0; reset 0.
- `mem_waitrequest` in 1: bus not ready; the request is held while high.
- `mem_readdata` in 32: valid the cycle after acceptance.

## Operation
FSM states: IDLE, READ, CAPTURE, DELIVER, SETTLE.
- IDLE: if `stall`=1, latch `req_addr = {addr[31:2],2'b00}`. Next edge: `mem_address`=`req_addr`, `mem_read`=1, go to READ.
- READ: hold `mem_address`/`mem_read` stable. Edge with `mem_waitrequest`=0 accepts the request; then `mem_read`←0 and go to CAPTURE.
- CAPTURE: register `mem_readdata` into `data_in`.
  - If `stall`=1 and `addr[31:2]`==`req_addr[31:2]`: `data_valid`←1, go to DELIVER.
  - Otherwise (stale, fetch redirected): discard the word, `data_valid` stays 0, go to SETTLE.
- DELIVER: `data_valid` high for exactly this cycle; the cache writes on this edge. Next edge `data_valid`←0, go to SETTLE.
- SETTLE: one dead cycle so the cache hit/stall path settles. No new request is issued. Next edge go to IDLE.
- An accepted bus read is always completed. The block never aborts once `mem_read`=1.
- `stall` dropping in READ does not deassert `mem_read` before acceptance.
- `data_in` holds its last value outside DELIVER.

## Timing
- Zero-wait-state memory: `stall` rises at cycle 0.
  - Cycle 1: `mem_read`=1.
  - Cycle 2: CAPTURE, `data_valid` scheduled.
  - Cycle 3: `data_valid`=1.
  - Cycle 4: SETTLE.
  - Earliest next request: cycle 5.
- Each cycle of `mem_waitrequest`=1 adds one cycle.
- Miss latency from `stall` to `data_valid` = 3 + wait cycles.
- Reset mid-operation: the next edge forces IDLE and all outputs to their reset values, including `mem_read`=0. The bus is assumed to be reset together with this block.
- `stall` high in SETTLE is ignored; it is sampled again in IDLE.

## Configuration
- Macro `MIPS_ICACHE_FILL_STATS_EN`.
- Defined: adds outputs `fill_count` (32, count of DELIVER entries) and `wait_count` (32, count of READ cycles with `mem_waitrequest`=1).
  - Both counters wrap at 2^32 and reset to 0.
  - Discarded stale fills are not counted in `fill_count`.
- Undefined: ports and counters are absent; FSM behaviour is identical.

## Structure
- Shared package `mips_cache_pkg` holds:
  - the FSM state enum `fill_state_t`;
  - `WORD_ALIGN_MASK` = 32'hFFFF_FFFC;
  - `BYTEEN_WORD` = 4'b1111.
- No sub-module. One FSM `always_ff` block plus output registers; 120–250 lines.

## Test plan
- Reset then idle: `stall`=0 for 10 cycles → `mem_read`=0, `data_valid`=0, `data_in`=0 throughout.
- Single miss, no waits: `addr`=0xBFC0_0002, `stall`=1, `mem_readdata`=0x2408_0005 → `mem_address`=0xBFC0_0000 at cycle 1; `data_valid`=1 with `data_in`=0x2408_0005 at cycle 3 for one cycle only.
- Wait states: `mem_waitrequest`=1 for 4 cycles → `mem_address` and `mem_read` stable across all 4 cycles; `data_valid` at cycle 7; `wait_count`=4 (stats build).
- Redirect mid-fill: in READ, `addr` changes 0x100→0x200 → bus read of 0x100 completes, no `data_valid`, SETTLE, then a new request for 0x200.
- Back-to-back misses at 0x0, 0x4 → second `mem_read` no earlier than cycle 5; two pulses; `fill_count`=2.
- Reset in READ with `mem_waitrequest`=1 → next cycle `mem_read`=0, state IDLE, no `data_valid`.

Source files
------------

// File: rtl/mips_cache_pkg.sv
// Shared types and constants for the MIPS instruction-cache refill path.
package mips_cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCapture,
    StDeliver,
    StSettle
  } fill_state_t;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [3:0]  BYTEEN_WORD     = 4'b1111;

endpackage

// File: rtl/mips_cache_instr_fill.sv
// Single-word refill engine between the instruction cache and an Avalon-style read bus.
// Optional MIPS_ICACHE_FILL_STATS_EN adds fill_count / wait_count statistics outputs.
module mips_cache_instr_fill
  import mips_cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              stall,
  output logic [DATA_W-1:0] data_in,
  output logic              data_valid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic [3:0]        mem_byteenable,
  input  logic              mem_waitrequest,
`ifdef MIPS_ICACHE_FILL_STATS_EN
  output logic [31:0]       fill_count,
  output logic [31:0]       wait_count,
`endif
  input  logic [DATA_W-1:0] mem_readdata
);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              mem_read_q, mem_read_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              data_valid_q, data_valid_d;

`ifdef MIPS_ICACHE_FILL_STATS_EN
  logic [31:0] fill_count_q, fill_count_d;
  logic [31:0] wait_count_q, wait_count_d;
`endif

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    mem_read_d   = mem_read_q;
    data_in_d    = data_in_q;
    data_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (stall) begin
          req_addr_d = addr & ADDR_W'(WORD_ALIGN_MASK);
          mem_read_d = 1'b1;
          state_d    = StRead;
        end
      end
      StRead: begin
        // Once issued the read is never withdrawn, even if the fetch moves on.
        if (!mem_waitrequest) begin
          mem_read_d = 1'b0;
          state_d    = StCapture;
        end
      end
      StCapture: begin
        if (stall && (addr[ADDR_W-1:2] == req_addr_q[ADDR_W-1:2])) begin
          data_in_d    = mem_readdata;
          data_valid_d = 1'b1;
          state_d      = StDeliver;
        end else begin
          state_d = StSettle;
        end
      end
      StDeliver: state_d = StSettle;
      StSettle:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

`ifdef MIPS_ICACHE_FILL_STATS_EN
  always_comb begin
    fill_count_d = fill_count_q;
    wait_count_d = wait_count_q;
    if (data_valid_d) fill_count_d = fill_count_q + 32'd1;
    if ((state_q == StRead) && mem_waitrequest) wait_count_d = wait_count_q + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      req_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      data_in_q    <= '0;
      data_valid_q <= 1'b0;
`ifdef MIPS_ICACHE_FILL_STATS_EN
      fill_count_q <= '0;
      wait_count_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      mem_read_q   <= mem_read_d;
      data_in_q    <= data_in_d;
      data_valid_q <= data_valid_d;
`ifdef MIPS_ICACHE_FILL_STATS_EN
      fill_count_q <= fill_count_d;
      wait_count_q <= wait_count_d;
`endif
    end
  end

  assign data_in        = data_in_q;
  assign data_valid     = data_valid_q;
  assign mem_address    = req_addr_q;
  assign mem_read       = mem_read_q;
  assign mem_byteenable = mem_read_q ? BYTEEN_WORD : 4'b0000;

`ifdef MIPS_ICACHE_FILL_STATS_EN
  assign fill_count = fill_count_q;
  assign wait_count = wait_count_q;
`endif

endmodule
